imem_fetch_arbiter: RTL and testbench

Sequencer and two-port arbiter in front of `instruction_memory` (four byte-wide synchronous ROMs, big-endian word assembly, 32-bit byte address `A`). Shares the single read port between the CPU fetch unit and a debug/loader read port. Performs range checking and read-latency sequencing, and returns each word with a one-cycle valid pulse. Fetch has priority, and a starvation counter guarantees debug progress.

---
 rtl/imem_fetch_arbiter.sv | 148 ++++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: shares the single instruction_memory read port between
// the CPU fetch unit and a debug/loader port. Fetch has priority; a starvation
// counter forces a debug grant after MAX_STARVE consecutive fetch grants.
//
// Handshake: a requester raises req with a stable addr and holds both until it
// sees gnt high in the same cycle. gnt is only issued in IDLE. The response
// comes back later as a one-cycle rvalid pulse on the owner's port, with
// rdata/err valid in that cycle; there is no back-pressure on the response.
module imem_fetch_arbiter #(
  parameter int unsigned ADDR_LIMIT = 393216,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic [31:0] mem_A,
  input  logic [31:0] mem_RD,
  output logic [1:0]  dbg_state
);

  localparam int CNT_W = $clog2(RD_LATENCY + 2);
  localparam int SC_W  = $clog2(MAX_STARVE + 2);
  localparam logic [31:0]      LAST_LEGAL = 32'(ADDR_LIMIT - 4);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(RD_LATENCY);
  localparam logic [SC_W-1:0]  SC_MAX     = SC_W'(MAX_STARVE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       mem_a_q, mem_a_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              owner_q, owner_d;   // 1 = debug owns the transaction
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SC_W-1:0]   starve_q, starve_d;

  logic              pick_d, pick_f, in_idle, any_gnt, sel_legal;
  logic [31:0]       sel_addr;

  // Arbitration decision; only acted upon while in IDLE
  always_comb begin
    pick_d    = d_req && (!f_req || (starve_q == SC_MAX));
    pick_f    = f_req && !pick_d;
    in_idle   = (state_q == S_IDLE) && !rst;
    any_gnt   = in_idle && (pick_d || pick_f);
    sel_addr  = pick_d ? d_addr : f_addr;
    sel_legal = (sel_addr <= LAST_LEGAL);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: illegal grants skip WAIT and respond immediately
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (any_gnt) state_d = sel_legal ? S_WAIT : S_RESP;
      S_WAIT: if (cnt_q == CNT_LAST) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: combinational grants in IDLE, rvalid pulse to the owner in RESP
  always_comb begin
    f_gnt     = in_idle && pick_f;
    d_gnt     = in_idle && pick_d;
    f_rvalid  = (state_q == S_RESP) && !owner_q;
    d_rvalid  = (state_q == S_RESP) &&  owner_q;
    busy      = (state_q != S_IDLE);
    dbg_state = state_q;
    mem_A     = mem_a_q;
    rdata     = rdata_q;
    err       = err_q;
  end

  // Datapath next values: address launch, latency count, capture, starvation
  always_comb begin
    mem_a_d  = mem_a_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    case (state_q)
      S_IDLE: begin
        if (!d_req || pick_d) starve_d = '0;
        else if (pick_f && (starve_q != SC_MAX)) starve_d = starve_q + 1'b1;
        if (any_gnt) begin
          owner_d = pick_d;
          if (sel_legal) begin
            mem_a_d = sel_addr;
            cnt_d   = '0;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          rdata_d = mem_RD;
          err_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_a_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      mem_a_q  <= mem_a_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter: a default build (RD_LATENCY=1) and a
// RD_LATENCY=2 build, each fed by a byte-ROM model with matching read latency.
module tb_imem_fetch_arbiter;

  localparam logic [31:0] LAST_LEGAL = 32'd393212;

  logic        clk = 1'b0;
  logic        rst;
  // default build
  logic        f_req, d_req, f_gnt, d_gnt, f_rvalid, d_rvalid, err, busy;
  logic [31:0] f_addr, d_addr, rdata, mem_A, mem_RD;
  logic [1:0]  dbg_state;
  // RD_LATENCY = 2 build
  logic        f_req2, d_req2, f_gnt2, d_gnt2, f_rvalid2, d_rvalid2, err2, busy2;
  logic [31:0] f_addr2, d_addr2, rdata2, mem_A2, mem_RD2;
  logic [1:0]  dbg_state2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];   // {owner, err, rdata}

  // clock/reset block
  always #5 clk = ~clk;

  imem_fetch_arbiter u_dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .rdata(rdata), .err(err), .busy(busy), .mem_A(mem_A), .mem_RD(mem_RD),
    .dbg_state(dbg_state)
  );

  imem_fetch_arbiter #(.RD_LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .f_req(f_req2), .f_addr(f_addr2), .f_gnt(f_gnt2), .f_rvalid(f_rvalid2),
    .d_req(d_req2), .d_addr(d_addr2), .d_gnt(d_gnt2), .d_rvalid(d_rvalid2),
    .rdata(rdata2), .err(err2), .busy(busy2), .mem_A(mem_A2), .mem_RD(mem_RD2),
    .dbg_state(dbg_state2)
  );

  // ROM contents: byte at address a
  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {rom_byte(a), rom_byte(a + 32'd1), rom_byte(a + 32'd2), rom_byte(a + 32'd3)};
  endfunction

  // memory models: one and two clock edges of read latency
  logic [31:0] pipe1, pipe2a, pipe2b;
  always @(posedge clk) begin
    pipe1  <= rom_word(mem_A);
    pipe2a <= rom_word(mem_A2);
    pipe2b <= pipe2a;
  end
  assign mem_RD  = pipe1;
  assign mem_RD2 = pipe2b;

  // scoreboard: grants push the expected response, rvalid pulses pop it
  always @(negedge clk) begin
    if (!rst) begin
      if (f_gnt) exp_q.push_back({1'b0, f_addr > LAST_LEGAL, (f_addr > LAST_LEGAL) ? 32'd0 : rom_word(f_addr)});
      if (d_gnt) exp_q.push_back({1'b1, d_addr > LAST_LEGAL, (d_addr > LAST_LEGAL) ? 32'd0 : rom_word(d_addr)});
      if (f_rvalid || d_rvalid) begin
        n_checks++;
        if ((f_rvalid && d_rvalid) || exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_rvalid: got f_rvalid=%b d_rvalid=%b with %0d expected responses", f_rvalid, d_rvalid, exp_q.size());
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          if ({d_rvalid, err, rdata} !== e) begin
            n_fail++;
            $display("FAIL sb_resp: got owner=%b err=%b rdata=%h expected owner=%b err=%b rdata=%h",
                     d_rvalid, err, rdata, e[33], e[32], e[31:0]);
          end
        end
      end
    end
  end

  // driver: advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    f_req = 0; d_req = 0; f_addr = 0; d_addr = 0;
    f_req2 = 0; d_req2 = 0; f_addr2 = 0; d_addr2 = 0;
    cyc(); cyc();
    n_checks++;
    if ({f_gnt, d_gnt, f_rvalid, d_rvalid, busy, err} !== 6'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got gnt=%b%b rv=%b%b busy=%b err=%b st=%0d expected all 0", f_gnt, d_gnt, f_rvalid, d_rvalid, busy, err, dbg_state);
    end
    n_checks++;
    if (mem_A !== 32'd0 || rdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_data: got mem_A=%h rdata=%h expected 0 0", mem_A, rdata);
    end
    n_checks++;
    if ({f_gnt2, d_gnt2, f_rvalid2, d_rvalid2, busy2, err2} !== 6'b0 || mem_A2 !== 32'd0) begin
      n_fail++; $display("FAIL reset_lat2: got ctrl=%b mem_A=%h expected 0", {f_gnt2, d_gnt2, f_rvalid2, d_rvalid2, busy2, err2}, mem_A2);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_fetch_basic();
    f_req = 1; f_addr = 32'h10;
    #1;
    n_checks++;
    if (f_gnt !== 1'b1 || d_gnt !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_gnt: got f_gnt=%b d_gnt=%b busy=%b expected 1 0 0", f_gnt, d_gnt, busy);
    end
    cyc(); f_req = 0; #1;
    n_checks++;
    if (mem_A !== 32'h10 || busy !== 1'b1 || f_gnt !== 1'b0) begin
      n_fail++; $display("FAIL basic_memA: got mem_A=%h busy=%b f_gnt=%b expected 10 1 0", mem_A, busy, f_gnt);
    end
    cyc(); #1;
    n_checks++;
    if (f_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL basic_early: got f_rvalid=%b expected 0", f_rvalid);
    end
    cyc(); #1;
    n_checks++;
    if (f_rvalid !== 1'b1 || d_rvalid !== 1'b0 || rdata !== 32'h4A4B4849 || err !== 1'b0) begin
      n_fail++; $display("FAIL basic_resp: got rv=%b%b rdata=%h err=%b expected 10 4a4b4849 0", f_rvalid, d_rvalid, rdata, err);
    end
    cyc(); #1;
    n_checks++;
    if (f_rvalid !== 1'b0 || busy !== 1'b0 || rdata !== 32'h4A4B4849) begin
      n_fail++; $display("FAIL basic_after: got f_rvalid=%b busy=%b rdata=%h expected 0 0 4a4b4849", f_rvalid, busy, rdata);
    end
  endtask

  task automatic test_range();
    // ADDR_LIMIT-3: illegal, immediate error response
    d_req = 1; d_addr = 32'd393213;
    #1;
    n_checks++;
    if (d_gnt !== 1'b1 || f_gnt !== 1'b0) begin
      n_fail++; $display("FAIL ill_gnt: got d_gnt=%b f_gnt=%b expected 1 0", d_gnt, f_gnt);
    end
    cyc(); d_req = 0; #1;
    n_checks++;
    if (d_rvalid !== 1'b1 || f_rvalid !== 1'b0 || err !== 1'b1 || rdata !== 32'd0 || mem_A !== 32'h10) begin
      n_fail++; $display("FAIL ill_resp: got rv=%b%b err=%b rdata=%h mem_A=%h expected d 1 0 10", f_rvalid, d_rvalid, err, rdata, mem_A);
    end
    cyc(); #1;
    n_checks++;
    if (d_rvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ill_after: got d_rvalid=%b busy=%b expected 0 0", d_rvalid, busy);
    end
    // ADDR_LIMIT-4: last legal word
    d_req = 1; d_addr = 32'd393212;
    #1;
    n_checks++;
    if (d_gnt !== 1'b1) begin
      n_fail++; $display("FAIL edge_gnt: got d_gnt=%b expected 1", d_gnt);
    end
    cyc(); d_req = 0; #1;
    n_checks++;
    if (mem_A !== 32'h0005FFFC || d_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL edge_memA: got mem_A=%h d_rvalid=%b expected 0005fffc 0", mem_A, d_rvalid);
    end
    cyc(); cyc(); #1;
    n_checks++;
    if (d_rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h5C5D5E5F) begin
      n_fail++; $display("FAIL edge_resp: got d_rvalid=%b err=%b rdata=%h expected 1 0 5c5d5e5f", d_rvalid, err, rdata);
    end
    cyc();
    // 0xFFFFFFFC must not wrap into the legal range
    f_req = 1; f_addr = 32'hFFFFFFFC;
    #1;
    cyc(); f_req = 0; #1;
    n_checks++;
    if (f_rvalid !== 1'b1 || err !== 1'b1 || rdata !== 32'd0 || mem_A !== 32'h0005FFFC) begin
      n_fail++; $display("FAIL wrap_resp: got f_rvalid=%b err=%b rdata=%h mem_A=%h expected 1 1 0 0005fffc", f_rvalid, err, rdata, mem_A);
    end
    cyc();
    // unaligned legal address passes through
    f_req = 1; f_addr = 32'h101;
    #1;
    cyc(); f_req = 0; #1;
    n_checks++;
    if (mem_A !== 32'h101) begin
      n_fail++; $display("FAIL unaligned_memA: got mem_A=%h expected 00000101", mem_A);
    end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_starvation();
    int ng;
    cyc();
    f_req = 1; d_req = 1; f_addr = 32'h20; d_addr = 32'h40;
    ng = 0;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      #1;
      n_checks++;
      if (f_gnt && d_gnt) begin
        n_fail++; $display("FAIL starve_dual: got both gnt high in cycle %0d expected at most one", c);
      end
      if (f_gnt || d_gnt) begin
        n_checks++;
        if (d_gnt !== (ng % 5 == 4)) begin
          n_fail++; $display("FAIL starve_order: got d_gnt=%b at grant %0d expected %b", d_gnt, ng, (ng % 5 == 4));
        end
        ng++;
      end
      cyc();
    end
    f_req = 0; d_req = 0;
    n_checks++;
    if (ng != 10) begin
      n_fail++; $display("FAIL starve_count: got %0d grants expected 10", ng);
    end
    cyc(); cyc(); cyc(); cyc();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c <= 12; c++) begin
      f_req = (c <= 8);
      f_addr = 32'((c / 4) * 4);
      #1;
      n_checks++;
      if (f_gnt !== ((c % 4 == 0) && c <= 8) || f_rvalid !== (c % 4 == 3) || busy !== (c % 4 != 0)) begin
        n_fail++; $display("FAIL b2b_cycle%0d: got gnt=%b rvalid=%b busy=%b expected %b %b %b", c, f_gnt, f_rvalid, busy,
                            ((c % 4 == 0) && c <= 8), (c % 4 == 3), (c % 4 != 0));
      end
      cyc();
    end
    f_req = 0;
  endtask

  task automatic test_reset_mid();
    int ng;
    f_req = 1; d_req = 1; f_addr = 32'h30; d_addr = 32'h50;
    #1;
    n_checks++;
    if (f_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rmid_gnt: got f_gnt=%b expected 1", f_gnt);
    end
    cyc(); #1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    n_checks++;
    if ({f_gnt, d_gnt, f_rvalid, d_rvalid, busy, err} !== 6'b0 || dbg_state !== 2'd0 || mem_A !== 32'd0 || rdata !== 32'd0) begin
      n_fail++; $display("FAIL rmid_async: got ctrl=%b st=%0d mem_A=%h rdata=%h expected all 0",
                          {f_gnt, d_gnt, f_rvalid, d_rvalid, busy, err}, dbg_state, mem_A, rdata);
    end
    cyc();
    rst = 1'b0;
    // starvation count must restart from zero: four fetch grants then debug
    ng = 0;
    for (int c = 0; c < 30 && ng < 5; c++) begin
      #1;
      if (f_gnt || d_gnt) begin
        n_checks++;
        if (d_gnt !== (ng == 4) || f_gnt === d_gnt) begin
          n_fail++; $display("FAIL rmid_order: got f_gnt=%b d_gnt=%b at grant %0d expected d_gnt=%b", f_gnt, d_gnt, ng, (ng == 4));
        end
        ng++;
      end
      cyc();
    end
    f_req = 0; d_req = 0;
    n_checks++;
    if (ng != 5) begin
      n_fail++; $display("FAIL rmid_count: got %0d grants expected 5", ng);
    end
    cyc(); cyc(); cyc(); cyc();
  endtask

  task automatic test_latency2();
    f_req2 = 1; f_addr2 = 32'h100;
    #1;
    n_checks++;
    if (f_gnt2 !== 1'b1) begin
      n_fail++; $display("FAIL lat2_gnt: got f_gnt=%b expected 1", f_gnt2);
    end
    for (int c = 1; c <= 5; c++) begin
      cyc(); f_req2 = 0; #1;
      n_checks++;
      if (f_rvalid2 !== (c == 4) || busy2 !== (c <= 4)) begin
        n_fail++; $display("FAIL lat2_cycle%0d: got rvalid=%b busy=%b expected %b %b", c, f_rvalid2, busy2, (c == 4), (c <= 4));
      end
      if (c == 1) begin
        n_checks++;
        if (mem_A2 !== 32'h100) begin
          n_fail++; $display("FAIL lat2_memA: got %h expected 00000100", mem_A2);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (rdata2 !== 32'h5B5A5958 || err2 !== 1'b0) begin
          n_fail++; $display("FAIL lat2_data: got rdata=%h err=%b expected 5b5a5958 0", rdata2, err2);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_range();
    test_starvation();
    test_back_to_back();
    test_reset_mid();
    test_latency2();
    cyc();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d responses outstanding expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got no completion within 200000 time units expected completion");
    $fatal(1, "timeout");
  end

endmodule
